// File: rtl/fifo_pkg.sv
// Shared types for the fifo slice: data word, arbiter defaults and pop FSM states.
package fifo_pkg;

  localparam int unsigned DATA_W = 8;
  typedef logic [DATA_W-1:0] data_t;

  localparam int unsigned N_REQ_DEF    = 4;
  localparam int unsigned READ_LAT_DEF = 1;

  localparam int unsigned REQ_IDX_W = $clog2(N_REQ_DEF);
  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } pop_state_t;

endpackage

// File: rtl/fifo_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter  int unsigned N_REQ = N_REQ_DEF,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] winner,
  output logic             any_gnt
);

  int unsigned idx;

  always_comb begin
    gnt     = '0;
    winner  = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr) + i) % N_REQ;
      if (!any_gnt && req[IDX_W'(idx)]) begin
        any_gnt               = 1'b1;
        winner                = IDX_W'(idx);
        gnt[IDX_W'(idx)]      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Shares one fifo between N_REQ producers (round-robin push) and drains it to a valid/ready port.
// Optional FIFO_ARB_STATS_EN adds saturating grant/stall counters.
module fifo_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned READ_LAT = READ_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  data_t [N_REQ-1:0]        req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     fifo_push,
  output data_t                    fifo_data,
  input  logic                     fifo_full,
  output logic                     fifo_pop,
  input  logic                     fifo_empty,
  input  data_t                    fifo_rdata,
  output logic                     out_valid,
  output data_t                    out_data,
  input  logic                     out_ready
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic [$clog2(N_REQ)-1:0] stat_sel,
  output logic [15:0]              stat_gnt,
  output logic [15:0]              stat_stall
`endif
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(READ_LAT + 1);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] winner;
  logic [N_REQ-1:0] arb_gnt;
  logic             arb_any;
  logic             push_ok;

  // Push side: zero-latency grant, suppressed by reset and by a full fifo.
  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .winner  (winner),
    .any_gnt (arb_any)
  );

  assign push_ok   = rst && arb_any && !fifo_full;
  assign gnt       = push_ok ? arb_gnt : '0;
  assign fifo_push = push_ok;
  assign fifo_data = req_data[winner];
  assign ptr_nxt   = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (push_ok) begin
      ptr <= ptr_nxt;
    end
  end

  // Pop side: issue pop, wait out the RAM read latency, then hold the word until accepted.
  pop_state_t       state;
  pop_state_t       state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             out_valid_d;
  data_t            out_data_d;
  logic             pop_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    pop_c       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          cnt_d   = CNT_W'(READ_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          out_data_d  = fifo_rdata;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            cnt_d   = CNT_W'(READ_LAT);
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fifo_pop = rst && pop_c;

`ifdef FIFO_ARB_STATS_EN
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  logic [15:0] gnt_cnt [N_REQ];
  logic [15:0] stall_cnt;

  for (genvar g = 0; g < N_REQ; g++) begin : g_gnt_cnt
    always_ff @(posedge clk) begin
      if (!rst) begin
        gnt_cnt[g] <= '0;
      end else if (gnt[g] && gnt_cnt[g] != STAT_MAX) begin
        gnt_cnt[g] <= gnt_cnt[g] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (|req && fifo_full && stall_cnt != STAT_MAX) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Out-of-range selects (non power-of-two N_REQ) read as zero.
  assign stat_gnt   = (32'(stat_sel) < N_REQ) ? gnt_cnt[stat_sel] : '0;
  assign stat_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: directed vector table, corner-case sequences and a randomized
// run against a queue-based reference model with a behavioural fifo (READ_LAT = 1).
module tb_fifo_arbiter;
  import fifo_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned RL    = 1;
  localparam int          DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req = '0;
  data_t [N-1:0]    req_data = '0;
  logic [N-1:0]     gnt;
  logic             fifo_push;
  data_t            fifo_data;
  logic             fifo_full;
  logic             fifo_pop;
  logic             fifo_empty;
  data_t            fifo_rdata = '0;
  logic             out_valid;
  data_t            out_data;
  logic             out_ready = 1'b0;
  logic             force_full = 1'b0;
  int               fifo_cnt = 0;
  data_t            fq[$];
`ifdef FIFO_ARB_STATS_EN
  logic [1:0]       stat_sel = '0;
  logic [15:0]      stat_gnt;
  logic [15:0]      stat_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fifo_arbiter #(
    .N_REQ    (N),
    .READ_LAT (RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .fifo_push  (fifo_push),
    .fifo_data  (fifo_data),
    .fifo_full  (fifo_full),
    .fifo_pop   (fifo_pop),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_gnt   (stat_gnt),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural fifo with one-cycle read latency; flushed while rst is low.
  assign fifo_full  = force_full || (fifo_cnt >= DEPTH);
  assign fifo_empty = (fifo_cnt == 0);

  always @(posedge clk) begin
    if (!rst) begin
      fq.delete();
      fifo_cnt <= 0;
    end else begin
      if (fifo_pop && fq.size() > 0) fifo_rdata <= fq.pop_front();
      if (fifo_push) fq.push_back(fifo_data);
      fifo_cnt <= fq.size();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0; req = '0; force_full = 1'b0; out_ready = 1'b0;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         full;
    logic [N-1:0] exp_gnt;
  } vec_t;

  vec_t vecs[14];

  // Reference model state for the randomized run.
  logic [N-1:0] pend = '0;
  data_t        pdata [N];
  int           mptr = 0;
  data_t        sb[$];
  logic         prev_hold = 1'b0;
  data_t        prev_data = '0;

  task automatic rand_cycle(input bit allow_new);
    logic [N-1:0] exp_g;
    int           w;
    data_t        exp_d;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (allow_new && !pend[i] && $urandom_range(0, 2) == 0) begin
        pend[i]  = 1'b1;
        pdata[i] = 8'($urandom);
      end
      req_data[i] = pdata[i];
    end
    req        = pend;
    force_full = allow_new && ($urandom_range(0, 7) == 0);
    out_ready  = !allow_new || ($urandom_range(0, 3) != 0);
    #1;
    exp_g = '0;
    w     = -1;
    if (pend != '0 && !fifo_full) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend[(mptr + k) % N]) w = (mptr + k) % N;
      end
    end
    if (w >= 0) exp_g[w] = 1'b1;
    check("rand_gnt", 32'(gnt), 32'(exp_g));
    check("rand_push", 32'(fifo_push), 32'(w >= 0));
    if (w >= 0) begin
      check("rand_push_data", 32'(fifo_data), 32'(pdata[w]));
      pend[w] = 1'b0;
      mptr    = (w + 1) % N;
      sb.push_back(pdata[w]);
    end
    check("rand_pop_on_empty", 32'(fifo_pop && fifo_empty), 32'd0);
    if (prev_hold) begin
      check("rand_hold_valid", 32'(out_valid), 32'd1);
      check("rand_hold_data", 32'(out_data), 32'(prev_data));
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("rand_out_unexpected", 32'(out_valid), 32'd0);
      end else begin
        exp_d = sb.pop_front();
        check("rand_out_data", 32'(out_data), 32'(exp_d));
      end
    end
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
  endtask

  initial begin
    int  idx;
    bit  done;

    for (int i = 0; i < N; i++) req_data[i] = data_t'(8'h10 + i);

    // Reset holds everything quiet even with all requests raised.
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req = '1;
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_push", 32'(fifo_push), 32'd0);
      check("rst_pop", 32'(fifo_pop), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
    end

    // Round-robin rotation and full stall.
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001};
    vecs[1]  = '{4'b1111, 1'b0, 4'b0010};
    vecs[2]  = '{4'b1111, 1'b0, 4'b0100};
    vecs[3]  = '{4'b1111, 1'b0, 4'b1000};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0001};
    vecs[5]  = '{4'b0100, 1'b1, 4'b0000};
    vecs[6]  = '{4'b0100, 1'b1, 4'b0000};
    vecs[7]  = '{4'b0100, 1'b1, 4'b0000};
    vecs[8]  = '{4'b0100, 1'b0, 4'b0100};
    vecs[9]  = '{4'b1001, 1'b0, 4'b1000};
    vecs[10] = '{4'b1001, 1'b0, 4'b0001};
    vecs[11] = '{4'b0110, 1'b0, 4'b0010};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000};
    vecs[13] = '{4'b0011, 1'b0, 4'b0001};
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      rst = 1'b1; req = vecs[v].req; force_full = vecs[v].full; out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vecs[v].exp_gnt));
      check($sformatf("vec%0d_push", v), 32'(fifo_push), 32'(vecs[v].exp_gnt != '0));
      idx = -1;
      for (int i = 0; i < N; i++) if (vecs[v].exp_gnt[i]) idx = i;
      if (idx >= 0) check($sformatf("vec%0d_data", v), 32'(fifo_data), 32'h10 + 32'(idx));
    end

    // Drain with backpressure.
    do_reset(1);
    @(negedge clk);
    req = 4'b0001; req_data[0] = 8'hA5;
    #1 check("drain_gnt_a5", 32'(gnt), 32'b0001);
    @(negedge clk);
    req = 4'b0010; req_data[1] = 8'h3C;
    #1 check("drain_gnt_3c", 32'(gnt), 32'b0010);
    check("drain_first_pop", 32'(fifo_pop), 32'd1);
    @(negedge clk);
    req = '0;
    #1 check("drain_wait_valid", 32'(out_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 check("drain_hold_valid", 32'(out_valid), 32'd1);
      check("drain_hold_data", 32'(out_data), 32'hA5);
      check("drain_hold_nopop", 32'(fifo_pop), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("drain_hs_a5", 32'(out_data), 32'hA5);
    check("drain_hs_pop", 32'(fifo_pop), 32'd1);
    @(negedge clk);
    #1 check("drain_gap_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 check("drain_3c_valid", 32'(out_valid), 32'd1);
    check("drain_3c_data", 32'(out_data), 32'h3C);
    @(negedge clk);
    #1 check("drain_idle_valid", 32'(out_valid), 32'd0);
    check("drain_idle_pop", 32'(fifo_pop), 32'd0);

    // Empty guard.
    do_reset(1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1 check("empty_no_pop", 32'(fifo_pop), 32'd0);
    end

    // Reset during WAIT discards the in-flight word.
    do_reset(1);
    @(negedge clk);
    req = 4'b0001; req_data[0] = 8'h77; out_ready = 1'b0;
    #1 check("midrst_gnt", 32'(gnt), 32'b0001);
    @(negedge clk);
    req = '0;
    #1 check("midrst_pop", 32'(fifo_pop), 32'd1);
    @(negedge clk);
    rst = 1'b0; req = 4'b0010;
    #1 check("midrst_no_gnt", 32'(gnt), 32'd0);
    check("midrst_no_push", 32'(fifo_push), 32'd0);
    @(negedge clk);
    rst = 1'b1; req = '0;
    #1 check("midrst_valid0", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 check("midrst_valid1", 32'(out_valid), 32'd0);
    check("midrst_pop_after", 32'(fifo_pop), 32'd0);

`ifdef FIFO_ARB_STATS_EN
    do_reset(1);
    stat_sel = 2'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req = 4'b0100; out_ready = 1'b1;
      #1 check("stat_run_gnt", 32'(gnt), 32'b0100);
    end
    @(negedge clk);
    req = '0;
    #1 check("stat_gnt5", 32'(stat_gnt), 32'd5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req = 4'b0100; force_full = 1'b1;
      #1;
    end
    @(negedge clk);
    req = '0; force_full = 1'b0;
    #1 check("stat_stall3", 32'(stat_stall), 32'd3);
    do_reset(1);
    #1 check("stat_gnt_clr", 32'(stat_gnt), 32'd0);
    check("stat_stall_clr", 32'(stat_stall), 32'd0);
`endif

    // Randomized traffic against the reference model, then a bounded drain.
    do_reset(1);
    pend = '0; mptr = 0; sb.delete(); prev_hold = 1'b0;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      rand_cycle(1'b0);
      if (pend == '0 && sb.size() == 0 && !out_valid && fifo_empty) done = 1'b1;
    end
    check("rand_drain_done", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_arbiter.md
Name: fifo_arbiter

Overview:
- Controller that shares one fifo instance between N_REQ producers and sequences its drain into a valid/ready consumer.
- Push side: round-robin arbitration among requesters; at most one push per cycle; blocked while the FIFO reports full.
- Pop side: small FSM that issues fifo pops, absorbs the RAM read latency, and presents words on a registered valid/ready output.
- Sits between the requester blocks and the fifo top; it drives the fifo's push/pop/data_in and reads its full/empty/data_out.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- READ_LAT, 1, cycles from fifo pop to valid fifo data_out (1..3).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req  in  N_REQ  per-requester push request; requester holds req and req_data until granted
- req_data  in  N_REQ x data_t  per-requester write word
- gnt  out  N_REQ  one-hot, one-cycle pulse; word of that requester accepted this cycle
- fifo_push  out  1  to fifo push
- fifo_data  out  data_t  to fifo data_in
- fifo_full  in  1  from fifo full
- fifo_pop  out  1  to fifo pop
- fifo_empty  in  1  from fifo empty
- fifo_rdata  in  data_t  from fifo data_out
- out_valid  out  1  output word valid
- out_data  out  data_t  output word, registered
- out_ready  in  1  consumer accepts when out_valid & out_ready

Interface rule: one clock; reset is synchronous and active-low.

Behaviour:
Reset (rst==0 at a clk edge):
- Priority pointer = 0.
- Pop FSM = IDLE, latency counter = 0.
- out_valid = 0, out_data = 0.
- gnt, fifo_push, fifo_pop are combinational and forced to 0 while rst==0.
- Reset mid-operation discards any in-flight pop and the held word; no gnt is issued in that cycle.

Push arbitration (combinational grant, registered pointer):
- Winner = first i with req[i]==1, searching ptr, ptr+1, ... mod N_REQ.
- If any req and !fifo_full: gnt[winner]=1, fifo_push=1, fifo_data=req_data[winner]. Same cycle; zero latency.
- On a grant, ptr <= (winner+1) mod N_REQ, with wrap at N_REQ-1 -> 0. No grant: ptr unchanged.
- fifo_full==1: gnt=0, fifo_push=0, pointer frozen. Requesters keep waiting.
- fifo_full is trusted as-is; the arbiter never pushes when full is asserted.

Pop FSM:
- IDLE: if !fifo_empty -> fifo_pop=1 for one cycle, cnt<=READ_LAT, go WAIT.
- WAIT: cnt decrements each cycle; when cnt reaches 1, out_data<=fifo_rdata and out_valid<=1 at the next edge, go HOLD. fifo_pop=0 throughout WAIT.
- HOLD: out_valid=1, out_data stable.
  - If out_ready and !fifo_empty: fifo_pop=1 this cycle, go WAIT; out_valid drops next cycle.
  - If out_ready and fifo_empty: out_valid<=0, go IDLE.
  - If !out_ready: stay.
- Throughput is one word per READ_LAT+1 cycles; ordering is strictly FIFO.
- Never pops when fifo_empty==1.
- Simultaneous push and pop in the same cycle is legal and independent.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- Defined: adds ports stat_sel (in, $clog2(N_REQ)), stat_gnt (out, 16), stat_stall (out, 16).
  - Per-requester 16-bit saturating grant counters; stat_gnt = counter[stat_sel], combinational read.
  - stat_stall: 16-bit saturating count of cycles with |req && fifo_full.
  - All counters cleared by reset.
- Undefined: ports and counters absent; arbitration and pop behaviour identical.

Decomposition:
- fifo_pkg gains:
  - N_REQ_DEF, READ_LAT_DEF constants.
  - req_idx_t typedef.
  - enum pop_state_t {IDLE, WAIT, HOLD}.
- data_t is reused unchanged.
- One sub-module: rr_arbiter (req vector + pointer -> one-hot gnt, winner index, any_gnt). It is purely combinational; the pointer register stays in fifo_arbiter.

Test Plan:
- Reset: rst=0 for 2 cycles with req=4'b1111 -> gnt=0, fifo_push=0, fifo_pop=0, out_valid=0 throughout.
- Round-robin: req=4'b1111 held, fifo not full -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- Full stall: req=4'b0100 with fifo_full=1 for 3 cycles -> no gnt. Full drops -> gnt=0100 that cycle; pointer then 3.
- Drain with backpressure (READ_LAT=1): fifo holds A5, 3C; out_ready=0 -> out_valid=1 with A5, held stable.
  - Raise out_ready -> 3C presented 2 cycles after the A5 handshake, then IDLE with out_valid=0.
- Empty guard: fifo_empty=1 for 10 cycles -> fifo_pop never asserted.
- Mid-operation reset: rst=0 during WAIT -> next cycle IDLE, out_valid=0.
  - With FIFO_ARB_STATS_EN: after 5 grants to requester 2, stat_sel=2 reads 5; reset clears it to 0.
